// File: rtl/rv64g_reg_lock_tracker_pkg.sv
// Shared definitions for the RV64G register lock tracker slice.
// NUM_REGS        : tracked architectural registers (x0..x31, f0..f31)
// NUM_OUTSTANDING : maximum pending writers per register
// locks_t         : one lock bit per register
// lock_cnt_t      : per-register pending-writer counter
package rv64g_pkg;

  localparam int unsigned NUM_REGS        = 64;
  localparam int unsigned NUM_OUTSTANDING = 4;
  localparam int unsigned LOCK_CNT_W      = $clog2(NUM_OUTSTANDING + 1);

  typedef logic [NUM_REGS-1:0]   locks_t;
  typedef logic [LOCK_CNT_W-1:0] lock_cnt_t;

endpackage

// File: rtl/rv64g_reg_lock_tracker_counter.sv
// reg_lock_counter: one saturating up/down pending-writer counter.
// Ports:
//   clk_i, arst_i : clock, asynchronous active-high reset
//   inc           : one launch targeting this register (0/1)
//   dec           : number of writebacks releasing this register this cycle
//   clear         : synchronous clear, overrides inc/dec
//   cnt           : current pending-writer count (0..NOS)
//   locked        : cnt != 0, purely from state
//   ovf, udf      : this cycle's update clamped high / low (not sticky)
module reg_lock_counter
  import rv64g_pkg::*;
#(
  parameter int unsigned NOS = NUM_OUTSTANDING,
  parameter int unsigned CW  = $clog2(NOS + 1),
  parameter int unsigned DW  = 2
) (
  input  logic          clk_i,
  input  logic          arst_i,
  input  logic          inc,
  input  logic [DW-1:0] dec,
  input  logic          clear,
  output logic [CW-1:0] cnt,
  output logic          locked,
  output logic          ovf,
  output logic          udf
);

  // Two extra bits give headroom above NOS and a sign bit below zero.
  localparam int unsigned SW = CW + 2;
  localparam logic signed [SW-1:0] NOS_S = SW'(NOS);

  logic signed [SW-1:0] sum;
  logic [CW-1:0]        cnt_d;

  always_comb begin
    sum   = $signed(SW'(cnt)) + $signed(SW'(inc)) - $signed(SW'(dec));
    cnt_d = cnt;
    ovf   = 1'b0;
    udf   = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (sum[SW-1]) begin
      cnt_d = '0;
      udf   = 1'b1;
    end else if (sum > NOS_S) begin
      cnt_d = CW'(NOS);
      ovf   = 1'b1;
    end else begin
      cnt_d = sum[CW-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_d;
    end
  end

  assign locked = (cnt != '0);

endmodule

// File: rtl/rv64g_reg_lock_tracker.sv
// rv64g_reg_lock_tracker: counts outstanding writes per register so the
// launcher can check hazards before issuing.
// Ports:
//   clk_i, arst_i  : clock, asynchronous active-high reset
//   clear_i        : synchronous clear of all counters and error flags
//   launch_valid_i : launcher output valid
//   launch_ready_i : launcher output ready (launch = valid & ready)
//   launch_dst_i   : destination mask of the launched instruction
//   wb_valid_i     : per-port writeback release strobes
//   wb_idx_i       : per-port released register index, port p at [p*IW +: IW]
//   locks_o        : per-register "has a pending writer"
//   pending_o      : per-register counters, register r at [r*CW +: CW]
//   overflow_o     : sticky, a launch hit a saturated counter
//   underflow_o    : sticky, a writeback hit a zero counter
// Register 0 (x0) is never tracked: its lock and count are tied to zero.
module rv64g_reg_lock_tracker
  import rv64g_pkg::*;
#(
  parameter int unsigned NR  = NUM_REGS,
  parameter int unsigned NOS = NUM_OUTSTANDING,
  parameter int unsigned NWB = 2
) (
  input  logic                              clk_i,
  input  logic                              arst_i,
  input  logic                              clear_i,
  input  logic                              launch_valid_i,
  input  logic                              launch_ready_i,
  input  logic [NR-1:0]                     launch_dst_i,
  input  logic [NWB-1:0]                    wb_valid_i,
  input  logic [NWB*$clog2(NR)-1:0]         wb_idx_i,
  output logic [NR-1:0]                     locks_o,
  output logic [NR*$clog2(NOS+1)-1:0]       pending_o,
  output logic                              overflow_o,
  output logic                              underflow_o
);

  localparam int unsigned CW = $clog2(NOS + 1);
  localparam int unsigned IW = $clog2(NR);
  localparam int unsigned DW = $clog2(NWB + 1);

  logic          launch;
  logic [DW-1:0] dec_cnt [NR-1:1];
  logic [NR-1:1] ovf_vec;
  logic [NR-1:1] udf_vec;
  logic          x0_dst_unused;

  assign launch        = launch_valid_i & launch_ready_i;
  assign x0_dst_unused = launch_dst_i[0];

  // Popcount of index-decoder matches across writeback ports; index 0 never
  // matches because the loop starts at register 1.
  always_comb begin
    for (int unsigned r = 1; r < NR; r++) begin
      dec_cnt[r] = '0;
      for (int unsigned p = 0; p < NWB; p++) begin
        if (wb_valid_i[p] && (wb_idx_i[p*IW +: IW] == IW'(r))) begin
          dec_cnt[r] = dec_cnt[r] + DW'(1);
        end
      end
    end
  end

  assign locks_o[0]         = 1'b0;
  assign pending_o[CW-1:0]  = '0;

  for (genvar r = 1; r < NR; r++) begin : g_cnt
    reg_lock_counter #(
      .NOS (NOS),
      .CW  (CW),
      .DW  (DW)
    ) u_cnt (
      .clk_i  (clk_i),
      .arst_i (arst_i),
      .inc    (launch & launch_dst_i[r]),
      .dec    (dec_cnt[r]),
      .clear  (clear_i),
      .cnt    (pending_o[r*CW +: CW]),
      .locked (locks_o[r]),
      .ovf    (ovf_vec[r]),
      .udf    (udf_vec[r])
    );
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else if (clear_i) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (|ovf_vec) overflow_o  <= 1'b1;
      if (|udf_vec) underflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rv64g_reg_lock_tracker.sv
module tb_rv64g_reg_lock_tracker;

  localparam int unsigned NR  = 64;
  localparam int unsigned NOS = 4;
  localparam int unsigned NWB = 2;
  localparam int unsigned CW  = 3;
  localparam int unsigned IW  = 6;

  logic                 clk_i = 1'b0;
  logic                 arst_i;
  logic                 clear_i;
  logic                 launch_valid_i;
  logic                 launch_ready_i;
  logic [NR-1:0]        launch_dst_i;
  logic [NWB-1:0]       wb_valid_i;
  logic [NWB*IW-1:0]    wb_idx_i;
  logic [NR-1:0]        locks_o;
  logic [NR*CW-1:0]     pending_o;
  logic                 overflow_o;
  logic                 underflow_o;

  int tests_run    = 0;
  int tests_failed = 0;

  rv64g_reg_lock_tracker #(
    .NR  (NR),
    .NOS (NOS),
    .NWB (NWB)
  ) dut (
    .clk_i          (clk_i),
    .arst_i         (arst_i),
    .clear_i        (clear_i),
    .launch_valid_i (launch_valid_i),
    .launch_ready_i (launch_ready_i),
    .launch_dst_i   (launch_dst_i),
    .wb_valid_i     (wb_valid_i),
    .wb_idx_i       (wb_idx_i),
    .locks_o        (locks_o),
    .pending_o      (pending_o),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] pend(input int unsigned r);
    return pending_o[r*CW +: CW];
  endfunction

  task automatic idle();
    clear_i        = 1'b0;
    launch_valid_i = 1'b0;
    launch_ready_i = 1'b0;
    launch_dst_i   = '0;
    wb_valid_i     = '0;
    wb_idx_i       = '0;
  endtask

  task automatic launch(input logic [NR-1:0] dst);
    launch_valid_i = 1'b1;
    launch_ready_i = 1'b1;
    launch_dst_i   = dst;
  endtask

  task automatic wb(input logic v0, input logic [IW-1:0] i0,
                    input logic v1, input logic [IW-1:0] i1);
    wb_valid_i = {v1, v0};
    wb_idx_i   = {i1, i0};
  endtask

  // Advance one active edge, then settle away from it before sampling.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  logic [NR-1:0] one = 1;

  initial begin
    idle();
    arst_i = 1'b1;
    #12;
    arst_i = 1'b0;
    #1;
    check("reset_locks",   64'(locks_o), 64'h0);
    check("reset_pending", 64'(|pending_o), 64'h0);
    check("reset_ovf",     64'(overflow_o), 64'h0);
    check("reset_udf",     64'(underflow_o), 64'h0);

    // Valid without ready must not count as a launch.
    launch_valid_i = 1'b1; launch_dst_i = one << 6;
    tick(); idle();
    check("no_handshake_lock6", 64'(locks_o[6]), 64'h0);

    // 1: launch to x5, writeback two cycles later
    launch(one << 5);
    tick(); idle();
    check("t1_lock5_n1", 64'(locks_o[5]), 64'h1);
    check("t1_pend5_n1", 64'(pend(5)), 64'h1);
    tick();
    check("t1_lock5_n2", 64'(locks_o[5]), 64'h1);
    wb(1'b1, 6'd5, 1'b0, 6'd0);
    tick(); idle();
    check("t1_lock5_wb", 64'(locks_o[5]), 64'h0);
    check("t1_pend5_wb", 64'(pend(5)), 64'h0);

    // 2: three launches to 40, dual-port release, then one more release
    for (int i = 0; i < 3; i++) begin
      launch(one << 40);
      tick();
    end
    idle();
    check("t2_pend40_3", 64'(pend(40)), 64'h3);
    wb(1'b1, 6'd40, 1'b1, 6'd40);
    tick(); idle();
    check("t2_pend40_1", 64'(pend(40)), 64'h1);
    wb(1'b1, 6'd40, 1'b0, 6'd0);
    tick(); idle();
    check("t2_pend40_0", 64'(pend(40)), 64'h0);
    check("t2_udf",      64'(underflow_o), 64'h0);

    // 3: simultaneous launch and port-1 release on x7 nets to zero
    launch(one << 7);
    tick(); idle();
    check("t3_pend7_pre", 64'(pend(7)), 64'h1);
    launch(one << 7);
    wb(1'b0, 6'd0, 1'b1, 6'd7);
    tick(); idle();
    check("t3_pend7_net", 64'(pend(7)), 64'h1);
    check("t3_lock7_net", 64'(locks_o[7]), 64'h1);
    wb(1'b0, 6'd0, 1'b1, 6'd7);
    tick(); idle();
    check("t3_pend7_rel", 64'(pend(7)), 64'h0);

    // 4: saturation of x9, multi-bit mask, then clear (launch ignored)
    for (int i = 0; i < 4; i++) begin
      launch(one << 9);
      tick();
    end
    idle();
    check("t4_pend9_4",  64'(pend(9)), 64'h4);
    check("t4_ovf_pre",  64'(overflow_o), 64'h0);
    launch((one << 9) | (one << 10) | (one << 11));
    tick(); idle();
    check("t4_pend9_sat", 64'(pend(9)), 64'h4);
    check("t4_ovf",       64'(overflow_o), 64'h1);
    check("t4_locks_mask", 64'(locks_o), 64'h0000_0000_0000_0E00);
    clear_i = 1'b1;
    launch(one << 10);
    tick(); idle();
    check("t4_clr_locks",   64'(locks_o), 64'h0);
    check("t4_clr_pending", 64'(|pending_o), 64'h0);
    check("t4_clr_ovf",     64'(overflow_o), 64'h0);

    // 5: x0 is ignored; release of idle x12 sets underflow
    launch(one);
    wb(1'b1, 6'd0, 1'b1, 6'd0);
    tick(); idle();
    check("t5_lock0", 64'(locks_o[0]), 64'h0);
    check("t5_pend0", 64'(pend(0)), 64'h0);
    check("t5_ovf0",  64'(overflow_o), 64'h0);
    check("t5_udf0",  64'(underflow_o), 64'h0);
    wb(1'b1, 6'd12, 1'b0, 6'd0);
    tick(); idle();
    check("t5_udf12",  64'(underflow_o), 64'h1);
    check("t5_pend12", 64'(pend(12)), 64'h0);
    tick();
    check("t5_udf_sticky", 64'(underflow_o), 64'h1);
    clear_i = 1'b1;
    tick(); idle();
    check("t5_clr_udf", 64'(underflow_o), 64'h0);

    // 6: asynchronous reset drops locks without an edge
    launch((one << 3) | (one << 33));
    tick(); idle();
    check("t6_locks_pre", 64'(locks_o), 64'h0000_0002_0000_0008);
    #2;
    arst_i = 1'b1;
    #1;
    check("t6_locks_async", 64'(locks_o), 64'h0);
    check("t6_pend_async",  64'(|pending_o), 64'h0);
    arst_i = 1'b0;
    launch(one << 3);
    tick(); idle();
    check("t6_locks_post", 64'(locks_o), 64'h0000_0000_0000_0008);
    check("t6_pend3_post", 64'(pend(3)), 64'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rv64g_reg_lock_tracker.md
# rv64g_reg_lock_tracker

Tracks outstanding register writes so that hazards can be checked before an instruction is launched. It sits beside the register file and produces the per-register `locks` vector consumed by the instruction launcher. Locks are set when a launch handshake completes and released by writeback pulses from the execution units. Each register keeps a small counter of pending writers, so repeated writes to the same destination are tracked exactly.

## Interface
Parameters:
- `NR`, default `rv64g_pkg::NUM_REGS` (64): tracked registers. Index 0 is `x0`, 1..31 are integer, 32..63 are FP.
- `NOS`, default `rv64g_pkg::NUM_OUTSTANDING` (4): maximum pending writers per register. This is the counter saturation value.
- `NWB`, default 2: number of writeback release ports.
- `CW`, derived: `$clog2(NOS+1)`. This is the counter width.

Ports:
- `clk_i`, input, 1: clock. Single clock domain.
- `arst_i`, input, 1: asynchronous reset, active-high.
- `clear_i`, input, 1: synchronous clear of all counters and error flags.
- `launch_valid_i`, input, 1: launch monitor valid. Driven by the launcher output valid.
- `launch_ready_i`, input, 1: launch monitor ready. A launch happens when `launch_valid_i & launch_ready_i`.
- `launch_dst_i`, input, NR: one-hot (or zero) destination mask of the launched instruction.
- `wb_valid_i`, input, NWB: one writeback release strobe per port.
- `wb_idx_i`, input, NWB×$clog2(NR): register index released on each port.
- `locks_o`, output, NR: bit r is 1 while register r has at least one pending writer.
- `pending_o`, output, NR×CW: per-register counter value, for debug and the scoreboard.
- `overflow_o`, output, 1: sticky; a launch hit a saturated counter.
- `underflow_o`, output, 1: sticky; a writeback hit a zero counter.

## Operation
- Per register r, each cycle:
  - Increment `inc_r = launch & launch_dst_i[r]`, 0 or 1.
  - Decrement `dec_r` = number of ports with `wb_valid_i[p] & wb_idx_i[p]==r`, 0..NWB.
  - Next value: `cnt_r + inc_r - dec_r`, computed at CW+2 bits signed, then clamped to the range 0..NOS.
- Clamping:
  - If the result is below 0, the counter becomes 0 and `underflow_o` is set.
  - If the result is above NOS, the counter becomes NOS and `overflow_o` is set.
- Register 0:
  - `launch_dst_i[0]` and writebacks to index 0 are ignored.
  - `cnt_0`, `locks_o[0]` and `pending_o[0]` are constant 0.
- `locks_o[r] = (cnt_r != 0)`, driven from the register state with no combinational path from inputs.
- `launch_dst_i` is treated as a mask. Multiple set bits each increment their own counter.
- `clear_i`: all counters go to 0 and both error flags go to 0 on the next edge. All other inputs are ignored in that cycle.
- Reset: all counters are 0, `locks_o` = 0, `pending_o` = 0, `overflow_o` = 0, `underflow_o` = 0.
- Error flags are sticky until `clear_i` or reset.

## Timing
- A launch completing at edge N makes `locks_o[r]` read 1 from cycle N+1. The launcher sees the lock on the very next candidate.
- A writeback at edge N makes `locks_o[r]` drop after edge N (visible in cycle N+1) if the count reaches 0.
- A launch and a writeback to the same register in the same cycle net to 0. The counter and lock are unchanged, with no glitch.
- Two ports writing back the same register in the same cycle decrement it by 2.
- There is no backpressure. The block always accepts launches and writebacks.
- Asynchronous reset mid-operation drops all locks immediately. The first post-reset launch is counted normally.

## Structure
- `rv64g_pkg` holds `NUM_REGS`, `NUM_OUTSTANDING`, `locks_t`, and a new `lock_cnt_t` (`logic [CW-1:0]`).
- Sub-module `reg_lock_counter`: one saturating up/down counter with inputs `inc`, `dec[count]`, `clear`, and outputs `cnt`, `locked`, `ovf`, `udf`.
  - Instantiated NR-1 times in a generate loop.
  - The top level ORs the `ovf` and `udf` outputs into the sticky flags.
- Per-register decrement: a popcount of the index-decoder match across NWB ports.

## Test plan
1. Launch with `launch_dst_i`=1<<5, then writeback on port 0 with idx 5 two cycles later:
   - `locks_o[5]` reads 1 in cycles N+1 and N+2.
   - `locks_o[5]` reads 0 from the cycle after the writeback.
   - `pending_o[5]` follows 1 then 0.
2. Three launches to register 40, then writebacks to 40 on both ports in the same cycle, then one more writeback:
   - Count goes 3, then 1, then 0.
   - `underflow_o` stays 0.
3. Launch and port-1 writeback to register 7 in the same cycle while `cnt_7`=1: `cnt_7` stays 1 and `locks_o[7]` stays 1.
4. NOS+1 launches to register 9: `cnt_9` saturates at 4 and `overflow_o` is 1. Then `clear_i` for one cycle: all counters and both flags read 0.
5. Launch to register 0 and writeback to idx 0: `locks_o[0]` and `pending_o[0]` stay 0 and no flag is set. A writeback to idx 12 while `cnt_12`=0 sets `underflow_o`.
6. Assert `arst_i` asynchronously while registers 3 and 33 are locked: `locks_o` goes to 0 without a clock edge. A launch after reset release sets `locks_o[3]`=1 on the next cycle.
